// File: rtl/logic_unit_pipe.sv
// Single-stage bitwise logic unit behind a valid/ready handshake.
// The result and its flags are registered; op_count tracks delivered results.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic             err,
  output logic [CNT_W-1:0] op_count
);

  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] res;
  logic             res_err;

  // The output register can take a new result whenever its current one leaves.
  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (op)
      3'd0:    res = ~a;
      3'd1:    res = a & b;
      3'd2:    res = ~(a & b);
      3'd3:    res = a | b;
      3'd4:    res = ~(a | b);
      3'd5:    res = a ^ b;
      3'd6:    res = ~(a ^ b);
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b1;
      parity    <= 1'b0;
      err       <= 1'b0;
      op_count  <= '0;
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        y         <= res;
        zero      <= (res == '0);
        parity    <= ^res;
        err       <= res_err;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      // Saturate rather than wrap so a long run never reports a small count.
      if (out_xfer && (op_count != {CNT_W{1'b1}}))
        op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: the driver queues expected results,
// a negedge monitor checks each delivered result and the handshake rules.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  y;
  logic        zero, parity, err;
  logic [15:0] op_count;

  // small-counter instance used for the saturation check
  logic        v2 = 1'b0, r2 = 1'b0, rdy2, ov2, z2, p2, e2;
  logic [2:0]  op2 = 3'd1;
  logic [7:0]  a2 = 8'h0F, b2 = 8'hFF, y2;
  logic [2:0]  cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] y;
    logic       zero;
    logic       parity;
    logic       err;
  } res_t;

  res_t q[$];
  int   exp_count = 0;

  logic       prev_hold = 1'b0;
  logic [10:0] prev_out;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .zero(zero), .parity(parity), .err(err), .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .op(op2),
    .a(a2), .b(b2), .out_valid(ov2), .out_ready(r2), .y(y2),
    .zero(z2), .parity(p2), .err(e2), .op_count(cnt2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: ops pair up as (plain, inverted) around and/or/xor.
  function automatic res_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    res_t r;
    logic [7:0] base;
    if (o == 3'd7)      r.y = 8'h00;
    else if (o == 3'd0) r.y = ~x;
    else begin
      if (o <= 3'd2)      base = x & z;
      else if (o <= 3'd4) base = x | z;
      else                base = x ^ z;
      r.y = (o % 2 == 0) ? ~base : base;
    end
    r.err    = (o == 3'd7);
    r.zero   = (r.y == 8'h00);
    r.parity = ($countones(r.y) % 2) == 1;
    return r;
  endfunction

  // One driven cycle; when use_tab is set the expected y comes from the caller.
  task automatic cyc(input logic v, input logic [2:0] o, input logic [7:0] x,
                     input logic [7:0] z, input logic ordy,
                     input logic use_tab, input logic [7:0] ty);
    res_t e;
    @(posedge clk);
    #1;
    in_valid = v; op = o; a = x; b = z; out_ready = ordy;
    #1;
    if (v && in_ready) begin
      e = model(o, x, z);
      if (use_tab) begin
        e.y      = ty;
        e.zero   = (ty == 8'h00);
        e.parity = ($countones(ty) % 2) == 1;
        e.err    = (o == 3'd7);
      end
      q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; op = 3'd3; a = 8'hFF;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q.delete();
    exp_count = 0;
  endtask

  // Monitor: delivery checks, op_count tracking, hold stability.
  always @(negedge clk) begin
    res_t got, e;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      chk("op_count", op_count, exp_count);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_result", {y, zero, parity, err}, prev_out);
      end
      if (out_valid && out_ready) begin
        got = '{y: y, zero: zero, parity: parity, err: err};
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %0h expected none", got);
        end else begin
          e = q.pop_front();
          chk("result", got, e);
        end
        if (exp_count < 16'hFFFF) exp_count++;
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {y, zero, parity, err};
    end
  end

  initial begin
    logic [7:0] sweep [8];
    int cnt2m;
    sweep = '{8'h3A, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_y", y, 8'h00);
    chk("rst_zero", zero, 1'b1);
    chk("rst_parity", parity, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_count", op_count, 16'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1'b1);

    // saturation on the 3-bit counter: max-1 is reached, then 3 more deliveries
    v2 = 1'b1; r2 = 1'b1; cnt2m = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("sat_count", cnt2, cnt2m[2:0]);
      if (ov2 && r2 && cnt2m < 7) cnt2m++;
    end
    @(negedge clk);
    chk("sat_final", cnt2, 3'd7);
    v2 = 1'b0; r2 = 1'b0;

    // op sweep
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 8'hC5, 8'h3A, 1'b1, 1'b1, sweep[i]);
    cyc(1'b1, 3'd0, 8'h07, 8'h00, 1'b1, 1'b1, 8'hF8);
    cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("par_y", y, 8'hF8);
    chk("par_parity", parity, 1'b1);
    chk("par_zero", zero, 1'b0);

    // backpressure
    cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 3'd5, 8'hF0, 8'h0F, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 3'd1, 8'hAA, 8'h55, 1'b0, 1'b1, 8'h00);
      chk("bp_ready", in_ready, 1'b0);
      chk("bp_y", y, 8'hFF);
    end
    cyc(1'b1, 3'd1, 8'hAA, 8'h55, 1'b1, 1'b1, 8'h00);
    cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("bp_second_valid", out_valid, 1'b1);
    chk("bp_second_y", y, 8'h00);
    chk("bp_second_zero", zero, 1'b1);

    // streaming
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom), 1'b1, 1'b0, 8'h00);
      if (i >= 1) chk("stream_valid", out_valid, 1'b1);
    end
    repeat (3) cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("stream_count", op_count, 16'd10);

    // reset while a result is held
    do_reset();
    cyc(1'b1, 3'd1, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF);
    cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("mid_valid_before", out_valid, 1'b1);
    do_reset();
    chk("mid_valid", out_valid, 1'b0);
    chk("mid_y", y, 8'h00);
    chk("mid_zero", zero, 1'b1);
    chk("mid_count", op_count, 16'h0);
    chk("mid_ready", in_ready, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
          8'($urandom), 1'($urandom_range(0, 9) < 7), 1'b0, 8'h00);

    // drain
    for (int i = 0; i < 20 && q.size() != 0; i++)
      cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the transaction counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream operand set is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand set this cycle.
REQ-007 The block SHALL have port op, input, 3 bits: operation select.
REQ-008 The block SHALL have ports a and b, inputs, WIDTH bits each: the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result register holds an undelivered result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result this cycle.
REQ-011 The block SHALL have port y, output, WIDTH bits: the registered result.
REQ-012 The block SHALL have ports zero, parity and err, outputs, 1 bit each: registered flags for the result in y.
REQ-013 The block SHALL have port op_count, output, CNT_W bits: the count of results delivered downstream.

Function
REQ-014 The op encoding SHALL be: 0 = ~a, 1 = a&b, 2 = ~(a&b), 3 = a|b, 4 = ~(a|b), 5 = a^b, 6 = ~(a^b), 7 = illegal.
REQ-015 All operations SHALL be bitwise across WIDTH bits; b SHALL be ignored for op 0.
REQ-016 For op 7, y SHALL be all zeros and err SHALL be 1; for ops 0-6, err SHALL be 0.
REQ-017 The zero flag SHALL be 1 exactly when the registered y is all zeros; this includes op 7.
REQ-018 The parity flag SHALL be the XOR-reduction of the registered y.
REQ-019 in_ready SHALL be combinationally equal to (!out_valid || out_ready).
REQ-020 An input transfer SHALL occur on a cycle where in_valid && in_ready; an output transfer SHALL occur on a cycle where out_valid && out_ready.
REQ-021 On an input transfer, y, zero, parity and err SHALL load the new result, and out_valid SHALL be 1 on the next cycle (latency 1 cycle).
REQ-022 On an output transfer with no input transfer in the same cycle, out_valid SHALL clear on the next cycle.
REQ-023 When an output transfer and an input transfer coincide, out_valid SHALL remain 1 and the new result SHALL replace the old one with no bubble; full throughput is 1 result per cycle.
REQ-024 While out_valid=1 and out_ready=0, y and all flags SHALL hold stable, and in_ready SHALL be 0.
REQ-025 in_valid=1 while in_ready=0 SHALL cause no state change.
REQ-026 op_count SHALL increment by 1 on each output transfer and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-027 No output SHALL depend combinationally on a, b or op.

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL clear out_valid, y, parity, err and op_count to 0 and set zero to 1, regardless of the handshake inputs.
REQ-029 Reset asserted mid-transaction SHALL discard the held result without delivering it, and op_count SHALL NOT increment in that cycle.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification (WIDTH=8, CNT_W=16)
REQ-031 Exhaustive op sweep: apply a=8'hC5, b=8'h3A with op 0..7 and out_ready=1 -> y = 3A, 00, FF, FF, 00, FF, 00, 00; err is 1 only for op 7; zero and parity match y.
REQ-032 Backpressure: hold out_ready=0, send op=5 with a=F0, b=0F, then present a second op=1 set -> y stays FF and in_ready stays 0; when out_ready rises, the second result 00 with zero=1 appears on the cycle after the transfer.
REQ-033 Streaming: hold in_valid=1 and out_ready=1 for 10 cycles with varying operands -> out_valid=1 every cycle from cycle 2 onward, each result lags its input by 1 cycle, and op_count=10 after drain.
REQ-034 Reset mid-operation: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, y=00, zero=1, op_count is unchanged at 0 and nothing is delivered.
REQ-035 Saturation: force or preload op_count to FFFE, then deliver 3 results -> op_count reads FFFF and holds.
REQ-036 Parity: a=8'h07 with op 0 -> y=F8, parity=1, zero=0.
